// File: rtl/apb_gpio_ctrl.sv
// APB3 GPIO slave: parametrised pin count, programmable wait states,
// per-pin level/edge interrupts with polarity, and pslverr on bad accesses.
module apb_gpio_ctrl #(
    parameter int unsigned GPIO_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [CNT_W-1:0]                r_cnt;
    logic [CNT_W-1:0]                w_cnt_nxt;

    logic [GPIO_W-1:0]               r_dout;
    logic [GPIO_W-1:0]               r_dir;
    logic [GPIO_W-1:0]               r_en;
    logic [GPIO_W-1:0]               r_type;
    logic [GPIO_W-1:0]               r_pol;
    logic [GPIO_W-1:0]               r_stat;
    logic [SYNC_STAGES-1:0][GPIO_W-1:0] r_sync;
    logic [GPIO_W-1:0]               r_prev;

    logic [2:0]                      w_off;
    logic                            w_upper;
    logic                            w_err;
    logic                            w_done;
    logic                            w_wr;
    logic [GPIO_W-1:0]               w_wdata;
    logic [GPIO_W-1:0]               w_w1c;
    logic [GPIO_W-1:0]               w_sync;
    logic [GPIO_W-1:0]               w_edge;
    logic [GPIO_W-1:0]               w_lvl;
    logic [GPIO_W-1:0]               w_evt;
    logic [31:0]                     w_rdata;
    logic                            w_unused;

    // Byte lane bits and any pwdata above the pin count carry no meaning here.
    assign w_unused = ^{paddr[1:0], pwdata};

    assign w_off   = paddr[4:2];
    assign w_upper = |(paddr >> 5);
    assign w_err   = w_upper || (pwrite && ((w_off == 3'd2) || (w_off == 3'd7)));
    assign w_wr    = w_done && !w_err && pwrite;
    assign w_wdata = pwdata[GPIO_W-1:0];
    assign w_w1c   = (w_wr && (w_off == 3'd6)) ? w_wdata : '0;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_edge  = (r_pol & w_sync & ~r_prev) | (~r_pol & ~w_sync & r_prev);
    assign w_lvl   = ~(w_sync ^ r_pol);
    assign w_evt   = (r_type & w_edge) | (~r_type & w_lvl);

    assign gpio_out = r_dout;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_stat & r_en);

    // FSM state register
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state; SETUP is the first penable cycle, ACCESS holds the wait states
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = CNT_W'(WAIT_STATES);
                end
            end
            S_SETUP, S_ACCESS: begin
                if (!(psel && penable)) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: transfer completes when the wait count has drained
    always_comb begin
        w_done  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (((r_state == S_SETUP) || (r_state == S_ACCESS)) && psel && penable
            && (r_cnt == '0) && !preset) begin
            w_done  = 1'b1;
            pready  = 1'b1;
            pslverr = w_err;
            prdata  = w_err ? 32'd0 : w_rdata;
        end
    end

    // Register read mux
    always_comb begin
        w_rdata = '0;
        case (w_off)
            3'd0:    w_rdata = 32'(r_dout);
            3'd1:    w_rdata = 32'(r_dir);
            3'd2:    w_rdata = 32'(w_sync);
            3'd3:    w_rdata = 32'(r_en);
            3'd4:    w_rdata = 32'(r_type);
            3'd5:    w_rdata = 32'(r_pol);
            3'd6:    w_rdata = 32'(r_stat);
            default: w_rdata = {16'h6710, 8'd0, 8'(GPIO_W)};
        endcase
    end

    // Control registers, input synchroniser and sticky status (set beats clear)
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_dout <= '0;
            r_dir  <= '0;
            r_en   <= '0;
            r_type <= '0;
            r_pol  <= '0;
            r_stat <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_prev <= w_sync;
            r_stat <= (r_stat & ~w_w1c) | w_evt;
            if (w_wr) begin
                case (w_off)
                    3'd0:    r_dout <= w_wdata;
                    3'd1:    r_dir  <= w_wdata;
                    3'd3:    r_en   <= w_wdata;
                    3'd4:    r_type <= w_wdata;
                    3'd5:    r_pol  <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Self-checking bench for apb_gpio_ctrl: directed scenarios plus random APB
// traffic and pad activity, compared each cycle against a register-level model.
module tb_apb_gpio_ctrl;

    localparam int unsigned GW = 8;
    localparam int unsigned AW = 12;
    localparam int unsigned WS = 2;
    localparam int unsigned SS = 2;

    logic          clk;
    logic          preset;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [GW-1:0] gpio_in, gpio_out, gpio_oe;
    logic          irq;

    apb_gpio_ctrl #(
        .GPIO_W(GW), .ADDR_W(AW), .WAIT_STATES(WS), .SYNC_STAGES(SS)
    ) dut (
        .pclk(clk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: register contents and the pad delay line
    logic [GW-1:0] m_dout, m_dir, m_en, m_type, m_pol, m_stat;
    logic [GW-1:0] m_pad [0:SS];

    // Expectations posted by the driver for the current cycle
    logic          exp_pready, exp_pslverr;
    logic [31:0]   exp_prdata;
    logic          pend;
    logic [2:0]    pend_off;
    logic [GW-1:0] pend_data;
    logic          pad_en_valid;
    logic [GW-1:0] pad_en_val;

    function automatic logic [GW-1:0] evt_f(input logic [GW-1:0] s, p, ty, po);
        logic [GW-1:0] e;
        for (int i = 0; i < GW; i++) begin
            if (ty[i]) e[i] = po[i] ? (s[i] && !p[i]) : (!s[i] && p[i]);
            else       e[i] = (s[i] == po[i]);
        end
        return e;
    endfunction

    function automatic logic [31:0] mread(input logic [2:0] off);
        case (off)
            3'd0:    return 32'(m_dout);
            3'd1:    return 32'(m_dir);
            3'd2:    return 32'(m_pad[SS-1]);
            3'd3:    return 32'(m_en);
            3'd4:    return 32'(m_type);
            3'd5:    return 32'(m_pol);
            3'd6:    return 32'(m_stat);
            default: return 32'h6710_0000 + 32'(GW);
        endcase
    endfunction

    always @(posedge clk) begin
        if (preset) begin
            m_dout <= '0; m_dir <= '0; m_en <= '0;
            m_type <= '0; m_pol <= '0; m_stat <= '0;
            for (int i = 0; i <= SS; i++) m_pad[i] <= '0;
        end else begin
            if (pend) begin
                case (pend_off)
                    3'd0: m_dout <= pend_data;
                    3'd1: m_dir  <= pend_data;
                    3'd3: m_en   <= pend_data;
                    3'd4: m_type <= pend_data;
                    3'd5: m_pol  <= pend_data;
                    default: ;
                endcase
            end
            m_stat <= (m_stat & ~((pend && pend_off == 3'd6) ? pend_data : '0))
                      | evt_f(m_pad[SS-1], m_pad[SS], m_type, m_pol);
            m_pad[0] <= gpio_in;
            for (int i = 1; i <= SS; i++) m_pad[i] <= m_pad[i-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bus_clear();
        pend = 1'b0;
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #2;
            bus_clear();
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    // One APB transfer; leaves the bus in its completion cycle
    task automatic apb(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        logic e;
        @(posedge clk); #2;
        bus_clear();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #2;
        penable = 1'b1;
        if (pad_en_valid) begin
            gpio_in = pad_en_val;
            pad_en_valid = 1'b0;
        end
        for (int k = 0; k < WS; k++) begin
            @(posedge clk); #2;
        end
        e = ((addr >> 5) != '0) || (wr && (addr[4:2] == 3'd2 || addr[4:2] == 3'd7));
        exp_pready  = 1'b1;
        exp_pslverr = e;
        exp_prdata  = e ? 32'd0 : mread(addr[4:2]);
        if (wr && !e) begin
            pend = 1'b1; pend_off = addr[4:2]; pend_data = wd[GW-1:0];
        end
        #1;
        rd = prdata;
        er = pslverr;
    endtask

    logic [31:0]   rd;
    logic          er;
    logic [AW-1:0] ra;
    int            rr;

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        pad_en_valid = 1'b0; pad_en_val = '0;
        bus_clear();
        pend_off = '0; pend_data = '0;

        @(posedge clk);
        fork
            forever begin
                @(negedge clk);
                chk("pready",   32'(pready),   32'(exp_pready));
                chk("pslverr",  32'(pslverr),  32'(exp_pslverr));
                chk("prdata",   prdata,        exp_prdata);
                chk("gpio_out", 32'(gpio_out), 32'(m_dout));
                chk("gpio_oe",  32'(gpio_oe),  32'(m_dir));
                chk("irq",      32'(irq),      32'(|(m_stat & m_en)));
            end
        join_none
        repeat (3) @(posedge clk);
        #2 preset = 1'b0;

        #1;
        chk("rst_gpio_out", 32'(gpio_out), 32'd0);
        chk("rst_irq",      32'(irq),      32'd0);

        apb(1'b0, AW'(32'h1C), 32'd0, rd, er);
        chk("id_data", rd, 32'h6710_0008);
        chk("id_err",  32'(er), 32'd0);

        apb(1'b1, AW'(32'h00), 32'h0000_00A5, rd, er);
        apb(1'b1, AW'(32'h04), 32'h0000_00FF, rd, er);
        idle(1); #1;
        chk("dout_a5", 32'(gpio_out), 32'h0000_00A5);
        chk("oe_ff",   32'(gpio_oe),  32'h0000_00FF);

        apb(1'b1, AW'(32'h00), 32'hFFFF_FFFF, rd, er);
        apb(1'b0, AW'(32'h00), 32'd0, rd, er);
        chk("dout_mask", rd, 32'h0000_00FF);

        apb(1'b1, AW'(32'h08), 32'h0000_0012, rd, er);
        chk("wr_datain_err", 32'(er), 32'd1);
        apb(1'b0, AW'(32'h20), 32'd0, rd, er);
        chk("rd_20_err",  32'(er), 32'd1);
        chk("rd_20_data", rd, 32'd0);
        apb(1'b0, AW'(32'h100), 32'd0, rd, er);
        chk("rd_100_err",  32'(er), 32'd1);
        chk("rd_100_data", rd, 32'd0);
        apb(1'b0, AW'(32'h00), 32'd0, rd, er);
        chk("dout_kept", rd, 32'h0000_00FF);

        // Rising-edge interrupt on pin 0
        apb(1'b1, AW'(32'h10), 32'h1, rd, er);
        apb(1'b1, AW'(32'h14), 32'h1, rd, er);
        apb(1'b1, AW'(32'h18), 32'hFF, rd, er);
        apb(1'b1, AW'(32'h0C), 32'h1, rd, er);
        idle(1);
        gpio_in[0] = 1'b1;
        idle(2); #1;
        chk("edge_irq_early", 32'(irq), 32'd0);
        idle(1); #1;
        chk("edge_irq_set", 32'(irq), 32'd1);
        apb(1'b1, AW'(32'h18), 32'h1, rd, er);
        idle(4); #1;
        chk("edge_irq_clr", 32'(irq), 32'd0);

        // Level-low interrupt on pin 3
        apb(1'b1, AW'(32'h0C), 32'h8, rd, er);
        apb(1'b1, AW'(32'h18), 32'h8, rd, er);
        idle(1); #1;
        chk("lvl_resets", 32'(irq), 32'd1);
        gpio_in[3] = 1'b1;
        idle(3);
        apb(1'b1, AW'(32'h18), 32'h8, rd, er);
        idle(1); #1;
        chk("lvl_clr", 32'(irq), 32'd0);

        // W1C and rising edge on pin 1 in the same cycle
        apb(1'b1, AW'(32'h10), 32'h3, rd, er);
        apb(1'b1, AW'(32'h14), 32'h3, rd, er);
        apb(1'b1, AW'(32'h18), 32'h2, rd, er);
        apb(1'b0, AW'(32'h18), 32'd0, rd, er);
        chk("pin1_clear", rd & 32'h2, 32'd0);
        pad_en_val = gpio_in | GW'(2);
        pad_en_valid = 1'b1;
        apb(1'b1, AW'(32'h18), 32'h2, rd, er);
        apb(1'b0, AW'(32'h18), 32'd0, rd, er);
        chk("set_beats_w1c", rd & 32'h2, 32'h2);

        // Reset during the completion cycle of a DATA_OUT write
        idle(1);
        @(posedge clk); #2;
        bus_clear();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = '0; pwdata = 32'h3C;
        @(posedge clk); #2 penable = 1'b1;
        for (int k = 0; k < WS; k++) begin
            @(posedge clk); #2;
        end
        preset = 1'b1;
        #1 chk("rst_mid_pready", 32'(pready), 32'd0);
        @(posedge clk); #2;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        apb(1'b0, AW'(32'h00), 32'd0, rd, er);
        chk("rst_mid_dout", rd, 32'd0);

        for (int t = 0; t < 300; t++) begin
            rr = int'($urandom_range(0, 15));
            ra = AW'($urandom_range(0, 7) * 4);
            if (rr == 0) ra = ra | AW'(32'h20);
            else if (rr == 1) ra = ra | AW'(32'h100);
            if ($urandom_range(0, 3) == 0) gpio_in = GW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                pad_en_val = GW'($urandom);
                pad_en_valid = 1'b1;
            end
            apb(1'($urandom_range(0, 1)), ra, $urandom, rd, er);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
